switch_debounce8: RTL and testbench

Debounces and synchronises the eight raw slide switches and the enable switch before they reach the 8-to-3 priority encoder / seven-segment stage. Each of the nine channels is passed through a two-flop synchroniser and then a tick-based stability filter. The filtered `x[7:0]` and `en` drive the encoder's data and enable inputs directly. `changed` flags every update of the filtered value.

---
 rtl/switch_debounce8_if.sv | 14 +
 rtl/switch_debounce8.sv | 132 +++++++++++++
 tb/tb_switch_debounce8.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/switch_debounce8_if.sv
// Switch-debounce bus: raw switch levels in, filtered levels and strobes out.
interface switch_debounce8_if;
  logic [7:0] sw_raw;
  logic       en_raw;
  logic [7:0] x;
  logic       en;
  logic       changed;
  logic       tick;

  // master: the board/bench side driving raw switches
  modport master (output sw_raw, en_raw, input x, en, changed, tick);
  // slave: the debouncer itself
  modport slave  (input sw_raw, en_raw, output x, en, changed, tick);
endinterface

// File: rtl/switch_debounce8.sv
// Nine-channel switch debouncer: 2-flop synchroniser, shared sample-tick
// prescaler, and a per-channel tick-based stability filter.

// One filter channel. cnt counts consecutive ticks on which the synchronised
// input disagrees with the accepted level; any agreeing tick clears it.
module switch_debounce8_chan #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d,
  output logic q,
  output logic upd
);
  typedef enum logic {IDLE, PENDING} st_e;

  localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);

  logic [3:0] cnt, cnt_nx;
  logic       q_nx;
  st_e        st;

  // state register: mismatch count and accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      q   <= q_nx;
    end
  end

  // next state: count mismatching ticks, accept on the last, drop on revert
  always_comb begin
    cnt_nx = cnt;
    q_nx   = q;
    upd    = 1'b0;
    st     = (cnt == 4'd0) ? IDLE : PENDING;
    if (tick) begin
      case (st)
        IDLE: begin
          if (d != q) begin
            if (LAST == 4'd0) begin
              q_nx = d;
              upd  = 1'b1;
            end else begin
              cnt_nx = 4'd1;
            end
          end
        end
        PENDING: begin
          if (d == q) begin
            cnt_nx = 4'd0;
          end else if (cnt == LAST) begin
            q_nx   = d;
            cnt_nx = 4'd0;
            upd    = 1'b1;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        default: cnt_nx = 4'd0;
      endcase
    end
  end
endmodule

module switch_debounce8 #(
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  switch_debounce8_if.slave   bus
);
  localparam int NCH = 9;
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [NCH-1:0] s1, s2, q, upd;
  logic [PW-1:0]  pcnt;
  logic           tick_r, changed_r;

  // two-flop synchroniser for the asynchronous switch levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.en_raw, bus.sw_raw};
      s2 <= s1;
    end
  end

  // free-running prescaler; tick is high for the cycle after the wrap value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      tick_r <= 1'b0;
    end else begin
      pcnt   <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
      tick_r <= (pcnt == PLAST);
    end
  end

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      switch_debounce8_chan #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_r),
        .d    (s2[i]),
        .q    (q[i]),
        .upd  (upd[i])
      );
    end
  endgenerate

  // one pulse per tick on which any channel accepted a new level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_r <= 1'b0;
    else     changed_r <= |upd;
  end

  assign bus.x       = q[7:0];
  assign bus.en      = q[8];
  assign bus.changed = changed_r;
  assign bus.tick    = tick_r;
endmodule

// File: tb/tb_switch_debounce8.sv
// Directed bench: instance A (TICK_DIV=1, STABLE_TICKS=4) runs the vector
// table and the reset cases; instance B (TICK_DIV=4, STABLE_TICKS=2) covers
// prescaled timing.
module tb_switch_debounce8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  switch_debounce8_if ifa ();
  switch_debounce8_if ifb ();

  switch_debounce8 #(.TICK_DIV(1), .STABLE_TICKS(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  switch_debounce8 #(.TICK_DIV(4), .STABLE_TICKS(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic       enr;
    logic [7:0] ex;
    logic       een;
    logic       ech;
  } vec_t;

  vec_t tv [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit found;

    // table: each entry is one cycle; inputs driven before the edge,
    // outputs checked just after it (A has a 6-edge latency)
    for (int i = 0; i < 32; i++) begin
      tv[i].enr = 1'b0; tv[i].een = 1'b0; tv[i].ech = 1'b0;
      if (i < 8) begin                       // single step 00 -> 10
        tv[i].sw = 8'h10;
        tv[i].ex = (i >= 5) ? 8'h10 : 8'h00;
        tv[i].ech = (i == 5);
      end else if (i < 16) begin             // step back to 00
        tv[i].sw = 8'h00;
        tv[i].ex = (i < 13) ? 8'h10 : 8'h00;
        tv[i].ech = (i == 13);
      end else if (i < 24) begin             // 3-cycle glitch on bit 3
        tv[i].sw = (i < 19) ? 8'h08 : 8'h00;
        tv[i].ex = 8'h00;
      end else begin                         // simultaneous A5 + enable
        tv[i].sw = 8'hA5;
        tv[i].enr = 1'b1;
        tv[i].ex = (i >= 29) ? 8'hA5 : 8'h00;
        tv[i].een = (i >= 29);
        tv[i].ech = (i == 29);
      end
    end

    // reset held with all switches high
    ifa.sw_raw = 8'hFF; ifa.en_raw = 1'b1;
    ifb.sw_raw = 8'hFF; ifb.en_raw = 1'b1;
    #1;
    chk("rst_x_t0", ifa.x, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("rst_x", ifa.x, 8'h00);
      chk("rst_en", ifa.en, 1'b0);
      chk("rst_changed", ifa.changed, 1'b0);
      chk("rst_tick", ifa.tick, 1'b0);
    end
    ifa.sw_raw = 8'h00; ifa.en_raw = 1'b0;
    ifb.sw_raw = 8'h00; ifb.en_raw = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ifa.sw_raw = tv[i].sw; ifa.en_raw = tv[i].enr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_x", i), ifa.x, tv[i].ex);
      chk($sformatf("vec%0d_en", i), ifa.en, tv[i].een);
      chk($sformatf("vec%0d_changed", i), ifa.changed, tv[i].ech);
      chk($sformatf("vec%0d_tick", i), ifa.tick, 1'b1);
    end

    // asynchronous reset mid-cycle clears outputs without a clock edge
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_x", ifa.x, 8'h00);
    chk("arst_en", ifa.en, 1'b0);
    chk("arst_changed", ifa.changed, 1'b0);
    chk("arst_tick", ifa.tick, 1'b0);
    ifa.sw_raw = 8'h00; ifa.en_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // B: tick high after every 4th edge from release
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      chk($sformatf("b_tick_e%0d", e), ifb.tick, (e % 4 == 0));
    end

    // B: step bit 0, accepted 6..10 edges after the first sample
    @(negedge clk);
    ifb.sw_raw = 8'h01;
    found = 1'b0;
    k = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      @(posedge clk); #1;
      if (ifb.x[0]) begin
        found = 1'b1;
        k = e;
        chk("b_changed_on_update", ifb.changed, 1'b1);
      end
    end
    chk("b_step_seen", found, 1'b1);
    chk("b_latency_in_range", (k >= 6 && k <= 10), 1'b1);

    // A: reset while channel 0 is pending (cnt = 2)
    @(negedge clk);
    ifa.sw_raw = 8'h01;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("pend_rst_x", ifa.x, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("pend_rst_hold_x0", ifa.x[0], 1'b0);
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      chk($sformatf("pend_rel_x0_e%0d", e), ifa.x[0], (e == 6));
      chk($sformatf("pend_rel_chg_e%0d", e), ifa.changed, (e == 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
